// File: rtl/priv_mode_arbiter.sv
// priv_mode_arbiter
// -----------------------------------------------------------------------------
// Round-robin arbiter that lets several requesters change one shared
// privilege-mode register. The winning request code is latched, acknowledged
// with a one-cycle req_ready pulse and decoded into a 2-bit privilege level.
// mode_out carries that level with bit 2 always set. After each applied change
// the block holds off for COOLDOWN cycles before sampling requests again.
//
// Unsupported codes resolve to level 0 and set the sticky bad_code flag.
//
// Optional feature (macro PRIV_FSM_PARITY_EN):
//   The state register and the hold counter each carry an even-parity bit.
//   On any parity mismatch the FSM returns to IDLE, mode_out goes to the safe
//   value 3'b100, bad_code is set and any grant in flight is dropped.
//
// Parameters:
//   NUM_REQ    number of requesters (2..8)
//   COOLDOWN   HOLD cycles after each applied change (1..15)
//
// Ports:
//   clk         clock
//   rst_n       asynchronous, active-low reset
//   req_valid   per-requester request, held until its req_ready
//   req_code    requester i code at bits [3i+2:3i]
//   req_ready   one-hot, one-cycle acknowledge of the winner
//   mode_out    {1'b1, level[1:0]}
//   mode_valid  one-cycle pulse when mode_out is written
//   busy        high whenever the FSM is not in IDLE
//   bad_code    sticky flag for unsupported applied codes
// -----------------------------------------------------------------------------
module priv_mode_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int COOLDOWN = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [3*NUM_REQ-1:0]   req_code,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [2:0]             mode_out,
  output logic                   mode_valid,
  output logic                   busy,
  output logic                   bad_code
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARB   = 2'b01,
    APPLY = 2'b10,
    HOLD  = 2'b11
  } state_t;

  // Registers
  state_t             r_state;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_idx;
  logic [2:0]         r_code;
  logic [3:0]         r_cnt;
  logic [NUM_REQ-1:0] r_ready;
  logic [2:0]         r_mode;
  logic               r_mode_valid;
  logic               r_bad;

  // Next-state values
  state_t             w_state_next;
  logic [PW-1:0]      w_ptr_next;
  logic [PW-1:0]      w_idx_next;
  logic [2:0]         w_code_next;
  logic [3:0]         w_cnt_next;
  logic [NUM_REQ-1:0] w_ready_next;
  logic [2:0]         w_mode_next;
  logic               w_mode_valid_next;
  logic               w_bad_next;

  // Arbitration results
  logic               w_any;
  logic [PW-1:0]      w_win;
  logic [2:0]         w_code_arr [NUM_REQ];

`ifdef PRIV_FSM_PARITY_EN
  // Together with r_state these bits form the 3-bit even-parity state
  // register; r_cnt_par protects the hold counter.
  logic               r_state_par;
  logic               r_cnt_par;
  logic               w_par_err;
`endif

  // Per-requester code slices
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_code
      assign w_code_arr[gi] = req_code[3*gi +: 3];
    end
  endgenerate

  // Code -> level. Anything outside {3,4,5} is the safe level 0.
  function automatic logic [1:0] f_level(input logic [2:0] code);
    logic [1:0] lvl;
    case (code)
      3'd3:    lvl = 2'd3;
      3'd4:    lvl = 2'd2;
      3'd5:    lvl = 2'd1;
      default: lvl = 2'd0;
    endcase
    return lvl;
  endfunction

  // Codes 0,3,4,5 are the supported set; all others flag bad_code.
  function automatic logic f_code_bad(input logic [2:0] code);
    logic bad;
    case (code)
      3'd0, 3'd3, 3'd4, 3'd5: bad = 1'b0;
      default:                bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Round-robin pick: scan offsets from the highest down so the last hit,
  // which is the one kept, is the lowest index at or after r_ptr.
  always_comb begin : p_rr
    int j;
    w_any = 1'b0;
    w_win = '0;
    j     = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      j = int'(r_ptr) + off;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      if (req_valid[PW'(j)]) begin
        w_any = 1'b1;
        w_win = PW'(j);
      end
    end
  end

`ifdef PRIV_FSM_PARITY_EN
  assign w_par_err = (^{r_state_par, r_state}) | (^{r_cnt_par, r_cnt});
`endif

  // Next-state and registered-output logic
  always_comb begin : p_next
    w_state_next      = r_state;
    w_ptr_next        = r_ptr;
    w_idx_next        = r_idx;
    w_code_next       = r_code;
    w_cnt_next        = r_cnt;
    w_ready_next      = '0;
    w_mode_next       = r_mode;
    w_mode_valid_next = 1'b0;
    w_bad_next        = r_bad;

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_idx_next          = w_win;
          w_code_next         = w_code_arr[w_win];
          w_ready_next[w_win] = 1'b1;
          w_state_next        = ARB;
        end
      end
      ARB: begin
        // The latched code is used from here on; req_code is not re-read.
        w_mode_next       = {1'b1, f_level(r_code)};
        w_mode_valid_next = 1'b1;
        w_state_next      = APPLY;
      end
      APPLY: begin
        if (f_code_bad(r_code)) begin
          w_bad_next = 1'b1;
        end
        w_cnt_next   = 4'(COOLDOWN - 1);
        w_state_next = HOLD;
      end
      HOLD: begin
        if (r_cnt == 4'd0) begin
          w_ptr_next   = (r_idx == PW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

`ifdef PRIV_FSM_PARITY_EN
    if (w_par_err) begin
      w_state_next      = IDLE;
      w_cnt_next        = 4'd0;
      w_ready_next      = '0;
      w_mode_next       = 3'b100;
      w_mode_valid_next = 1'b0;
      w_bad_next        = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_regs
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_idx        <= '0;
      r_code       <= 3'd0;
      r_cnt        <= 4'd0;
      r_ready      <= '0;
      r_mode       <= 3'b100;
      r_mode_valid <= 1'b0;
      r_bad        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_ptr        <= w_ptr_next;
      r_idx        <= w_idx_next;
      r_code       <= w_code_next;
      r_cnt        <= w_cnt_next;
      r_ready      <= w_ready_next;
      r_mode       <= w_mode_next;
      r_mode_valid <= w_mode_valid_next;
      r_bad        <= w_bad_next;
    end
  end

`ifdef PRIV_FSM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin : p_par_regs
    if (!rst_n) begin
      r_state_par <= 1'b0;
      r_cnt_par   <= 1'b0;
    end else begin
      r_state_par <= ^w_state_next;
      r_cnt_par   <= ^w_cnt_next;
    end
  end
`endif

  assign req_ready  = r_ready;
  assign mode_out   = r_mode;
  assign mode_valid = r_mode_valid;
  assign bad_code   = r_bad;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_priv_mode_arbiter.sv
// Testbench for priv_mode_arbiter. A transaction-level timeline model predicts
// when each grant happens and derives every output from the grant edge.
module tb_priv_mode_arbiter;

  localparam int N = 4;
  localparam int C = 3;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [3*N-1:0] req_code;
  logic [N-1:0]   req_ready;
  logic [2:0]     mode_out;
  logic           mode_valid;
  logic           busy;
  logic           bad_code;

  priv_mode_arbiter #(.NUM_REQ(N), .COOLDOWN(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_code   (req_code),
    .req_ready  (req_ready),
    .mode_out   (mode_out),
    .mode_valid (mode_valid),
    .busy       (busy),
    .bad_code   (bad_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference tables straight from the code list
  int lvl_tab  [8] = '{0, 0, 0, 3, 2, 1, 0, 0};
  int good_tab [8] = '{1, 0, 0, 1, 1, 1, 0, 0};

  // Timeline model state
  int  e;            // number of active edges seen out of reset
  int  next_sample;  // first edge at which the block samples requests again
  int  m_ptr;
  bit  have_g;
  int  g;            // edge of the latest grant
  int  g_idx;
  int  g_code;
  int  exp_mode;
  int  exp_bad;
  bit  auto_drop;
  int  grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic model_reset();
    have_g      = 0;
    m_ptr       = 0;
    exp_mode    = 4;
    exp_bad     = 0;
    next_sample = e + 1;
  endtask

  task automatic model_edge();
    int w;
    bit found;
    e++;
    found = 0;
    w     = 0;
    if (e >= next_sample) begin
      for (int off = 0; off < N; off++) begin
        int j;
        j = (m_ptr + off) % N;
        if (!found && req_valid[j]) begin
          found = 1;
          w     = j;
        end
      end
    end
    if (found) begin
      have_g      = 1;
      g           = e;
      g_idx       = w;
      g_code      = int'(req_code[3*w +: 3]);
      m_ptr       = (w + 1) % N;
      next_sample = e + C + 3;
      grants.push_back(w);
      $display("grant req %0d code %0d at edge %0d", w, g_code, e);
    end
    if (have_g && e == g + 1) exp_mode = 4 + lvl_tab[g_code];
    if (have_g && e == g + 2 && good_tab[g_code] == 0) exp_bad = 1;
  endtask

  // One clock: model the active edge, then compare on the falling edge.
  task automatic step();
    logic [N-1:0] exp_ready;
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    @(negedge clk);
    exp_ready = '0;
    if (have_g && e == g) exp_ready[g_idx] = 1'b1;
    chk("req_ready",  32'(req_ready),  32'(exp_ready));
    chk("mode_out",   32'(mode_out),   32'(exp_mode));
    chk("mode_valid", 32'(mode_valid), 32'(have_g && e == g + 1));
    chk("busy",       32'(busy),       32'(have_g && e >= g && e <= g + C + 1));
    chk("bad_code",   32'(bad_code),   32'(exp_bad));
    if (auto_drop) begin
      for (int i = 0; i < N; i++) if (exp_ready[i]) req_valid[i] = 1'b0;
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_req(input int i, input int code);
    req_valid[i]         = 1'b1;
    req_code[3*i +: 3]   = 3'(code);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_ready", 32'(req_ready),  32'd0);
    chk("rst_mode",  32'(mode_out),   32'd4);
    chk("rst_mv",    32'(mode_valid), 32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_bad",   32'(bad_code),   32'd0);
    steps(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_code  = '0;
    auto_drop = 1;
    e         = 0;
    g         = 0;
    g_idx     = 0;
    g_code    = 0;
    model_reset();

    // Power-on reset
    do_reset();

    // Single requester 0, code 3
    set_req(0, 3);
    steps(C + 6);
    chk("t1_grants", 32'(grants.size()), 32'd1);

    // Requesters 0 and 2 together from ptr 0
    do_reset();
    grants.delete();
    set_req(0, 4);
    set_req(2, 5);
    steps(2 * (C + 3) + 3);
    chk("t2_ngrant", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) begin
      chk("t2_first",  32'(grants[0]), 32'd0);
      chk("t2_second", 32'(grants[1]), 32'd2);
    end

    // Unsupported code, then a legal one: bad_code stays set
    set_req(1, 7);
    steps(C + 4);
    chk("t3_bad_set", 32'(bad_code), 32'd1);
    set_req(3, 3);
    steps(C + 4);
    chk("t3_bad_hold", 32'(bad_code), 32'd1);

    // All requesters continuously valid: wrap-around order
    do_reset();
    grants.delete();
    auto_drop = 0;
    for (int i = 0; i < N; i++) set_req(i, 3 + (i % 3));
    steps(5 * (C + 3));
    chk("t4_ngrant", 32'(grants.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk("t4_order", 32'(grants[i]), 32'(i % N));

    // Reset during ARB, request kept valid and re-served afterwards
    do_reset();
    req_valid = '0;
    grants.delete();
    set_req(2, 4);
    step();
    chk("t5_in_arb", 32'(req_ready), 32'b0100);
    do_reset();
    step();
    chk("t5_regrant", 32'(grants.size()), 32'd2);
    auto_drop = 1;
    req_valid[2] = 1'b0;
    steps(C + 4);

    // Randomized traffic
    do_reset();
    req_valid = '0;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(3) == 0)
          set_req(i, int'($urandom_range(7)));
        else if (req_valid[i] && $urandom_range(40) == 0)
          req_valid[i] = 1'b0;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
